// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Wait counter width; clamped to 1 so an illegal WAIT_CYCLES still elaborates far enough to report.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module mem_access_ctrl_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (load)            count <= load_value;
    else if (dec && !zero_c)  count <= count - WIDTH'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response controller for the memory array and its shared tri-state data bus.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ready,
  output logic              valid,
  output logic              rw,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_oe,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be at least 1");
  end

  state_t            state, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] wdata_q;
  logic              bus_drive;
  logic              accept;
  logic              cnt_zero_c;
  logic              ready_d, valid_d, rw_d, mem_we_d, mem_oe_d, bus_drive_d;

  assign accept = ready && sel;
  assign op_d   = accept ? op : op_q;

  mem_access_ctrl_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (state == SETUP),
    .load_value (CNT_W'(WAIT_CYCLES - 1)),
    .dec        (state == ACCESS),
    .zero_c     (cnt_zero_c)
  );

  // State, request capture and registered outputs; reset drops strobes and the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_READ;
      wdata_q   <= '0;
      mem_addr  <= '0;
      rdata_out <= '0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      rw        <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      bus_drive <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      ready     <= ready_d;
      valid     <= valid_d;
      rw        <= rw_d;
      mem_we    <= mem_we_d;
      mem_oe    <= mem_oe_d;
      bus_drive <= bus_drive_d;
      if (accept) begin
        wdata_q  <= wdata_in;
        mem_addr <= addr_in;
      end
      if (state == ACCESS && cnt_zero_c && op_q == OP_READ) rdata_out <= data_bus;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (sel) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (cnt_zero_c) state_d = DONE;
      DONE:    state_d = sel ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    ready_d     = 1'b0;
    valid_d     = 1'b0;
    rw_d        = 1'b0;
    mem_we_d    = 1'b0;
    mem_oe_d    = 1'b0;
    bus_drive_d = 1'b0;
    case (state_d)
      IDLE:    ready_d = 1'b1;
      SETUP:   bus_drive_d = (op_d == OP_WRITE);
      ACCESS: begin
        bus_drive_d = (op_d == OP_WRITE);
        mem_we_d    = (op_d == OP_WRITE);
        mem_oe_d    = (op_d == OP_READ);
      end
      DONE: begin
        ready_d = 1'b1;
        valid_d = 1'b1;
        rw_d    = op_d;
      end
      default: ready_d = 1'b1;
    endcase
  end

  assign data_bus = bus_drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel1, op1, sel3, op3;
  logic [2:0] addr1, addr3;
  logic [7:0] wdata1, wdata3;
  logic       ready1, valid1, rw1, mem_we1, mem_oe1;
  logic       ready3, valid3, rw3, mem_we3, mem_oe3;
  logic [7:0] rdata1, rdata3;
  logic [2:0] mem_addr1, mem_addr3;
  wire  [7:0] bus1, bus3;

  logic [7:0] arr1 [8];
  logic [7:0] arr3 [8];

  int passed = 0;
  int total  = 0;

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sel(sel1), .op(op1), .addr_in(addr1), .wdata_in(wdata1),
    .ready(ready1), .valid(valid1), .rw(rw1), .rdata_out(rdata1), .mem_addr(mem_addr1),
    .mem_we(mem_we1), .mem_oe(mem_oe1), .data_bus(bus1));

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .sel(sel3), .op(op3), .addr_in(addr3), .wdata_in(wdata3),
    .ready(ready3), .valid(valid3), .rw(rw3), .rdata_out(rdata3), .mem_addr(mem_addr3),
    .mem_we(mem_we3), .mem_oe(mem_oe3), .data_bus(bus3));

  // Array models: preload word i with {i,i}, write on mem_we, drive the bus under mem_oe.
  assign bus1 = mem_oe1 ? arr1[mem_addr1] : 8'bz;
  assign bus3 = mem_oe3 ? arr3[mem_addr3] : 8'bz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) arr1[i] <= 8'(i * 17);
    end else if (mem_we1) arr1[mem_addr1] <= bus1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) arr3[i] <= 8'(i * 17);
    end else if (mem_we3) arr3[mem_addr3] <= bus3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel1 = 1'b1; op1 = 1'b1; addr1 = 3'd5; wdata1 = 8'hEE;
    sel3 = 1'b0; op3 = 1'b0; addr3 = 3'd0; wdata3 = 8'h00;
    repeat (3) tick();
    total++; if (ready1 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready1); else passed++;
    total++; if (valid1 !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid1); else passed++;
    total++; if (mem_we1 !== 1'b0 || mem_oe1 !== 1'b0) $display("FAIL reset_strobes: we=%b oe=%b want 0 0", mem_we1, mem_oe1); else passed++;
    total++; if (dut1.bus_drive !== 1'b0) $display("FAIL reset_bus_drive: got %b want 0", dut1.bus_drive); else passed++;
    total++; if (mem_addr1 !== 3'd0 || rdata1 !== 8'h00) $display("FAIL reset_regs: addr=%h rdata=%h want 0 00", mem_addr1, rdata1); else passed++;
    total++; if (dut1.state !== IDLE) $display("FAIL reset_state_sel_held: got %0d want IDLE", dut1.state); else passed++;
    sel1 = 1'b0;
    #2 reset = 1'b0;
    tick();
    total++; if (dut1.state !== IDLE || ready1 !== 1'b1) $display("FAIL post_reset_idle: state=%0d ready=%b want IDLE 1", dut1.state, ready1); else passed++;
  endtask

  task automatic test_write();
    sel1 = 1'b1; op1 = 1'b1; addr1 = 3'd5; wdata1 = 8'hA5;
    tick();
    total++; if (ready1 !== 1'b0) $display("FAIL wr_setup_ready: got %b want 0", ready1); else passed++;
    total++; if (mem_addr1 !== 3'd5) $display("FAIL wr_setup_addr: got %h want 5", mem_addr1); else passed++;
    total++; if (bus1 !== 8'hA5) $display("FAIL wr_setup_bus: got %h want a5", bus1); else passed++;
    total++; if (mem_we1 !== 1'b0 || mem_oe1 !== 1'b0) $display("FAIL wr_setup_strobes: we=%b oe=%b want 0 0", mem_we1, mem_oe1); else passed++;
    sel1 = 1'b0; wdata1 = 8'h00;
    tick();
    total++; if (mem_we1 !== 1'b1 || bus1 !== 8'hA5) $display("FAIL wr_access: we=%b bus=%h want 1 a5", mem_we1, bus1); else passed++;
    total++; if (valid1 !== 1'b0) $display("FAIL wr_access_valid: got %b want 0", valid1); else passed++;
    tick();
    total++; if (valid1 !== 1'b1 || rw1 !== 1'b1) $display("FAIL wr_done: valid=%b rw=%b want 1 1", valid1, rw1); else passed++;
    total++; if (mem_we1 !== 1'b0 || dut1.bus_drive !== 1'b0) $display("FAIL wr_turnaround: we=%b drive=%b want 0 0", mem_we1, dut1.bus_drive); else passed++;
    tick();
    total++; if (valid1 !== 1'b0) $display("FAIL wr_valid_pulse: got %b want 0", valid1); else passed++;
    total++; if (arr1[5] !== 8'hA5) $display("FAIL wr_array: got %h want a5", arr1[5]); else passed++;
  endtask

  task automatic test_read();
    sel1 = 1'b1; op1 = 1'b0; addr1 = 3'd5;
    tick();
    total++; if (mem_oe1 !== 1'b0 || dut1.bus_drive !== 1'b0) $display("FAIL rd_setup: oe=%b drive=%b want 0 0", mem_oe1, dut1.bus_drive); else passed++;
    sel1 = 1'b0;
    tick();
    total++; if (mem_oe1 !== 1'b1 || dut1.bus_drive !== 1'b0) $display("FAIL rd_access: oe=%b drive=%b want 1 0", mem_oe1, dut1.bus_drive); else passed++;
    total++; if (bus1 !== 8'hA5) $display("FAIL rd_access_bus: got %h want a5", bus1); else passed++;
    tick();
    total++; if (valid1 !== 1'b1 || rw1 !== 1'b0) $display("FAIL rd_done: valid=%b rw=%b want 1 0", valid1, rw1); else passed++;
    total++; if (rdata1 !== 8'hA5) $display("FAIL rd_data: got %h want a5", rdata1); else passed++;
    total++; if (mem_oe1 !== 1'b0) $display("FAIL rd_turnaround: oe=%b want 0", mem_oe1); else passed++;
    tick();
  endtask

  task automatic test_ignore_busy();
    sel1 = 1'b1; op1 = 1'b0; addr1 = 3'd3;
    tick();
    sel1 = 1'b1; op1 = 1'b1; addr1 = 3'd6; wdata1 = 8'hFF;
    tick();
    total++; if (mem_addr1 !== 3'd3) $display("FAIL ign_addr_access: got %h want 3", mem_addr1); else passed++;
    total++; if (mem_we1 !== 1'b0 || mem_oe1 !== 1'b1) $display("FAIL ign_op: we=%b oe=%b want 0 1", mem_we1, mem_oe1); else passed++;
    sel1 = 1'b0; addr1 = 3'd7;
    tick();
    total++; if (valid1 !== 1'b1 || rw1 !== 1'b0) $display("FAIL ign_done: valid=%b rw=%b want 1 0", valid1, rw1); else passed++;
    total++; if (rdata1 !== 8'h33 || mem_addr1 !== 3'd3) $display("FAIL ign_data: rdata=%h addr=%h want 33 3", rdata1, mem_addr1); else passed++;
    tick();
    total++; if (dut1.state !== IDLE) $display("FAIL ign_idle: got %0d want IDLE", dut1.state); else passed++;
    total++; if (arr1[6] !== 8'h66) $display("FAIL ign_no_write: got %h want 66", arr1[6]); else passed++;
  endtask

  task automatic test_back_to_back();
    sel3 = 1'b1; op3 = 1'b1; addr3 = 3'd2; wdata3 = 8'h3C;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 1) begin
        op3 = 1'b0; wdata3 = 8'h00;
      end
      total++;
      if (valid3 !== ((e == 5) || (e == 10))) $display("FAIL b2b_valid_e%0d: got %b want %b", e, valid3, (e == 5) || (e == 10));
      else passed++;
      if (e == 3) begin
        total++; if (mem_we3 !== 1'b1) $display("FAIL b2b_we_e3: got %b want 1", mem_we3); else passed++;
      end
      if (e == 5) begin
        total++; if (rw3 !== 1'b1 || ready3 !== 1'b1) $display("FAIL b2b_done1: rw=%b ready=%b want 1 1", rw3, ready3); else passed++;
      end
      if (e == 6) begin
        total++; if (dut3.state !== SETUP || ready3 !== 1'b0) $display("FAIL b2b_no_idle: state=%0d ready=%b want SETUP 0", dut3.state, ready3); else passed++;
      end
      if (e == 10) begin
        total++; if (rw3 !== 1'b0 || rdata3 !== 8'h3C) $display("FAIL b2b_done2: rw=%b rdata=%h want 0 3c", rw3, rdata3); else passed++;
      end
    end
    sel3 = 1'b0;
    tick();
    total++; if (dut3.state !== IDLE || valid3 !== 1'b0) $display("FAIL b2b_end: state=%0d valid=%b want IDLE 0", dut3.state, valid3); else passed++;
  endtask

  task automatic test_reset_mid_write();
    sel1 = 1'b1; op1 = 1'b1; addr1 = 3'd4; wdata1 = 8'h5A;
    tick();
    sel1 = 1'b0;
    tick();
    total++; if (mem_we1 !== 1'b1) $display("FAIL rst_mid_pre: we=%b want 1", mem_we1); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (mem_we1 !== 1'b0 || dut1.bus_drive !== 1'b0) $display("FAIL rst_mid_drop: we=%b drive=%b want 0 0", mem_we1, dut1.bus_drive); else passed++;
    total++; if (dut1.state !== IDLE || ready1 !== 1'b1) $display("FAIL rst_mid_state: state=%0d ready=%b want IDLE 1", dut1.state, ready1); else passed++;
    for (int e = 0; e < 3; e++) begin
      tick();
      total++; if (valid1 !== 1'b0) $display("FAIL rst_mid_valid_%0d: got %b want 0", e, valid1); else passed++;
    end
    #3 reset = 1'b0;
    tick();
    total++; if (valid1 !== 1'b0 || dut1.state !== IDLE) $display("FAIL rst_mid_after: valid=%b state=%0d want 0 IDLE", valid1, dut1.state); else passed++;
    total++; if (rdata1 !== 8'h00) $display("FAIL rst_mid_rdata: got %h want 00", rdata1); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
